// File: rtl/sipo_deser.sv
// sipo_deser: serial-in parallel-out deserializer.
// Assembles a serial bit stream into WIDTH-bit words and presents each word in
// a one-word holding register (q / q_valid / q_ready).
// Optional feature macro: SIPO_PARITY_EN adds a trailing parity bit per word
// (DATA -> PAR phase) and drives q_perr. ODD_PARITY selects the parity sense.
//
// Handshake semantics (both sides):
//   A transfer happens on a posedge where valid && ready are both 1.
//   Serial side: sin_valid/sin_ready. sin_ready only drops when the next
//   accepted bit would complete a word while the holding register is full and
//   not being drained this cycle. It is combinational from q_ready.
//   Parallel side: q_valid/q_ready. q_valid stays high and q stays stable until
//   q_ready is seen. A drain and a completion on the same edge reload q
//   without a bubble.
module sipo_deser #(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             q_perr,
  output logic             busy
);

  // Parameter sanity checks at elaboration.
  if (WIDTH < 2) begin : g_width_check
    $error("sipo_deser: WIDTH must be at least 2");
  end
  if ((ODD_PARITY != 0) && (ODD_PARITY != 1)) begin : g_parity_check
    $error("sipo_deser: ODD_PARITY must be 0 or 1");
  end

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  // DATA: collecting data bits. PAR: waiting for the parity bit.
  typedef enum logic {
    PH_DATA = 1'b0,
    PH_PAR  = 1'b1
  } phase_t;

  phase_t           phase, phase_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] sr, sr_nxt, sr_shift;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             q_valid_r, q_valid_nxt;
  logic             last_data;
  logic             completing_next;
  logic             accept;
  logic             load;

  // Shift direction decides where the first received bit ends up.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign sr_shift = {sr[WIDTH-2:0], sin};
  end else begin : g_lsb_first
    assign sr_shift = {sin, sr[WIDTH-1:1]};
  end

  assign last_data = (phase == PH_DATA) && (count == LAST_IDX);

`ifdef SIPO_PARITY_EN
  // The parity bit is the one that completes a word.
  assign completing_next = (phase == PH_PAR);
`else
  // The WIDTH-th data bit completes a word.
  assign completing_next = last_data;
`endif

  assign sin_ready = !(completing_next && q_valid_r && !q_ready);
  assign accept    = sin_valid && sin_ready && !flush;

  // Next-state logic for the assembly path and the holding register.
  always_comb begin
    phase_nxt   = phase;
    count_nxt   = count;
    sr_nxt      = sr;
    q_nxt       = q_r;
    q_valid_nxt = q_valid_r;
    load        = 1'b0;

    if (flush) begin
      phase_nxt = PH_DATA;
      count_nxt = '0;
      sr_nxt    = '0;
    end else if (accept) begin
      if (phase == PH_DATA) begin
        sr_nxt = sr_shift;
        if (last_data) begin
          count_nxt = '0;
`ifdef SIPO_PARITY_EN
          phase_nxt = PH_PAR;
`else
          q_nxt = sr_shift;
          load  = 1'b1;
`endif
        end else begin
          count_nxt = count + CW'(1);
        end
      end else begin
        // Parity bit: the data word is already complete in sr.
        phase_nxt = PH_DATA;
        q_nxt     = sr;
        load      = 1'b1;
      end
    end

    if (load) begin
      q_valid_nxt = 1'b1;
    end else if (q_valid_r && q_ready) begin
      q_valid_nxt = 1'b0;
    end
  end

  // State registers; clr wins over every other input.
  always_ff @(posedge clk) begin
    if (clr) begin
      phase     <= PH_DATA;
      count     <= '0;
      sr        <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      phase     <= phase_nxt;
      count     <= count_nxt;
      sr        <= sr_nxt;
      q_r       <= q_nxt;
      q_valid_r <= q_valid_nxt;
    end
  end

`ifdef SIPO_PARITY_EN
  localparam logic ODD_BIT = (ODD_PARITY != 0);
  logic perr_r;

  // Parity flag follows the word into the holding register.
  always_ff @(posedge clk) begin
    if (clr) begin
      perr_r <= 1'b0;
    end else if (!flush && accept && (phase == PH_PAR)) begin
      perr_r <= ((^sr) ^ sin) != ODD_BIT;
    end
  end

  assign q_perr = perr_r;
`else
  assign q_perr = 1'b0;
`endif

  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign busy    = (count != '0) || (phase == PH_PAR);

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: scoreboard bench for sipo_deser. Two instances (MSB-first and
// LSB-first) share one stimulus stream. Honours SIPO_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_sipo_deser;

  localparam int WIDTH = 4;
`ifdef SIPO_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int NBITS = WIDTH + PAR_EN;
  localparam int ODD   = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr, sin, sin_valid, flush, q_ready;
  logic             sin_ready_m, q_valid_m, perr_m, busy_m;
  logic             sin_ready_l, q_valid_l, perr_l, busy_l;
  logic [WIDTH-1:0] q_m, q_l;

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1), .ODD_PARITY(ODD)) u_msb (
    .clk(clk), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(sin_ready_m), .flush(flush), .q(q_m), .q_valid(q_valid_m),
    .q_ready(q_ready), .q_perr(perr_m), .busy(busy_m)
  );

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(0), .ODD_PARITY(ODD)) u_lsb (
    .clk(clk), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(sin_ready_l), .flush(flush), .q(q_l), .q_valid(q_valid_l),
    .q_ready(q_ready), .q_perr(perr_l), .busy(busy_l)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH:0] exp_q_m[$];
  logic [WIDTH:0] exp_q_l[$];
  logic bits[$];       // bits of the word in progress, first received first
  logic hold = 1'b0;   // reference view of "holding register occupied"
  bit   model_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model + driver ----------------
  // Called at posedge+1; drives one cycle of inputs and advances the model.
  task automatic step(input logic v, input logic b, input logic fl,
                      input logic qr, input logic c);
    logic exp_ready, accept, completing;
    logic [WIDTH-1:0] wm, wl;
    logic perr;
    int ones;
    sin_valid = v; sin = b; flush = fl; q_ready = qr; clr = c;
    exp_ready = !((bits.size() == NBITS - 1) && hold && !qr);
    @(negedge clk);
    if (model_known) begin
      chk("sin_ready_msb", 32'(sin_ready_m), 32'(exp_ready));
      chk("sin_ready_lsb", 32'(sin_ready_l), 32'(exp_ready));
      chk("busy_msb", 32'(busy_m), 32'(bits.size() != 0));
      chk("busy_lsb", 32'(busy_l), 32'(bits.size() != 0));
    end
    accept = v && exp_ready && !fl && !c;
    @(posedge clk);
    if (c) begin
      bits.delete();
      hold = 1'b0;
      exp_q_m.delete();
      exp_q_l.delete();
      model_known = 1'b1;
    end else begin
      completing = accept && (bits.size() == NBITS - 1);
      if (accept) bits.push_back(b);
      if (completing) begin
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
          wm[WIDTH-1-i] = bits[i];
          wl[i]         = bits[i];
        end
        for (int i = 0; i < bits.size(); i++) ones += int'(bits[i]);
        perr = (PAR_EN != 0) ? ((ones % 2) != ODD) : 1'b0;
        exp_q_m.push_back({perr, wm});
        exp_q_l.push_back({perr, wl});
        bits.delete();
        hold = 1'b1;
      end else if (hold && qr) begin
        hold = 1'b0;
      end
      if (fl) bits.delete();
    end
    #1;
  endtask

  // Bit idx of the serial stream for word w (data MSB first, then even parity).
  function automatic logic stream_bit(input logic [WIDTH-1:0] w, input int idx);
    if (idx < WIDTH) return w[WIDTH-1-idx];
    return ^w;
  endfunction

  task automatic send_word(input logic [WIDTH-1:0] w, input logic qr);
    for (int i = 0; i < NBITS; i++) step(1'b1, stream_bit(w, i), 1'b0, qr, 1'b0);
  endtask

  task automatic idle(input int n, input logic qr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, qr, 1'b0);
  endtask

  // ---------------- monitor ----------------
  task automatic take_word(input string name, input logic [WIDTH:0] act, inout logic [WIDTH:0] q_in[$]);
    if (q_in.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got unexpected word %0h, expected none (t=%0t)", name, act, $time);
    end else begin
      chk(name, 32'(act), 32'(q_in.pop_front()));
    end
  endtask

  // Compare each word as the consumer takes it.
  always @(negedge clk) begin
    if (model_known && !clr && q_ready) begin
      if (q_valid_m) take_word("word_msb", {perr_m, q_m}, exp_q_m);
      if (q_valid_l) take_word("word_lsb", {perr_l, q_l}, exp_q_l);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] nxt;
    clr = 1'b1; sin = 1'b0; sin_valid = 1'b0; flush = 1'b0; q_ready = 1'b0;
    @(posedge clk); #1;

    // Reset with live serial input.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_q", 32'(q_m), 32'd0);
    chk("rst_q_valid", 32'(q_valid_m), 32'd0);
    chk("rst_q_perr", 32'(perr_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_sin_ready", 32'(sin_ready_m), 32'd1);

    // MSB-first / LSB-first word 1011.
    send_word(4'b1011, 1'b1);
    chk("word1_q_msb", 32'(q_m), 32'hB);
    chk("word1_q_lsb", 32'(q_l), 32'hD);
    chk("word1_valid", 32'(q_valid_m), 32'd1);
    idle(1, 1'b1);
    chk("word1_valid_one_cycle", 32'(q_valid_m), 32'd0);
    chk("word1_q_retained", 32'(q_m), 32'hB);

    // Back-pressure: hold 1011, build 0110 up to its completing bit.
    send_word(4'b1011, 1'b0);
    nxt = 4'b0110;
    for (int i = 0; i < NBITS - 1; i++) step(1'b1, stream_bit(nxt, i), 1'b0, 1'b0, 1'b0);
    step(1'b1, stream_bit(nxt, NBITS - 1), 1'b0, 1'b0, 1'b0);
    chk("bp_stalled_q", 32'(q_m), 32'hB);
    step(1'b1, stream_bit(nxt, NBITS - 1), 1'b0, 1'b1, 1'b0);
    chk("bp_release_q", 32'(q_m), 32'h6);
    chk("bp_release_valid", 32'(q_valid_m), 32'd1);
    idle(1, 1'b1);

    // Flush with gaps.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush_busy", 32'(busy_m), 32'd0);
    send_word(4'b0011, 1'b1);
    chk("flush_word_q", 32'(q_m), 32'h3);
    idle(1, 1'b1);

    // Mid-word reset.
    send_word(4'b1011, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, stream_bit(4'b0101, i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("midrst_q", 32'(q_m), 32'd0);
    chk("midrst_valid", 32'(q_valid_m), 32'd0);
    chk("midrst_busy", 32'(busy_m), 32'd0);
    chk("midrst_perr", 32'(perr_m), 32'd0);

`ifdef SIPO_PARITY_EN
    // Even parity: 1011 + 0 is wrong, 1011 + 1 is right.
    begin
      logic [4:0] pv;
      pv = 5'b10110;
      for (int i = 4; i >= 0; i--) step(1'b1, pv[i], 1'b0, 1'b1, 1'b0);
      chk("par_bad_q", 32'(q_m), 32'hB);
      chk("par_bad_perr", 32'(perr_m), 32'd1);
      pv = 5'b10111;
      for (int i = 4; i >= 0; i--) step(1'b1, pv[i], 1'b0, 1'b1, 1'b0);
      chk("par_good_perr", 32'(perr_m), 32'd0);
      idle(1, 1'b1);
    end
`endif

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 199) == 0));
    end

    // Drain and make sure every expected word came out.
    idle(4, 1'b1);
    chk("drain_q_valid", 32'(q_valid_m), 32'd0);
    chk("drain_empty_msb", 32'(exp_q_m.size()), 32'd0);
    chk("drain_empty_lsb", 32'(exp_q_l.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
